// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 set-2 scan-code decoder:
// prefix FSM states, special byte values and the tracked game-key table.
package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    EXT     = 2'd1,
    BRK     = 2'd2,
    EXT_BRK = 2'd3
  } state_t;

  localparam logic [7:0] PFX_EXT    = 8'hE0;
  localparam logic [7:0] PFX_BRK    = 8'hF0;
  localparam logic [7:0] RSP_ACK    = 8'hFA;
  localparam logic [7:0] RSP_BAT    = 8'hAA;
  localparam logic [7:0] RSP_RESEND = 8'hFE;
  localparam logic [7:0] RSP_ECHO   = 8'hEE;
  localparam logic [7:0] PFX_PAUSE  = 8'hE1;

  localparam int unsigned NUM_KEYS = 8;

  localparam logic [2:0] KEY_W     = 3'd0;
  localparam logic [2:0] KEY_A     = 3'd1;
  localparam logic [2:0] KEY_S     = 3'd2;
  localparam logic [2:0] KEY_D     = 3'd3;
  localparam logic [2:0] KEY_SPACE = 3'd4;
  localparam logic [2:0] KEY_ENTER = 3'd5;
  localparam logic [2:0] KEY_LEFT  = 3'd6;
  localparam logic [2:0] KEY_RIGHT = 3'd7;

  // Returns {hit, idx}; the extended flag is part of the match, so E0 5A
  // (keypad ENTER) does not alias ENTER.
  function automatic logic [3:0] key_index(input logic ext, input logic [7:0] code);
    logic [3:0] r;
    r = '0;
    case ({ext, code})
      9'h01D:  r = {1'b1, KEY_W};
      9'h01C:  r = {1'b1, KEY_A};
      9'h01B:  r = {1'b1, KEY_S};
      9'h023:  r = {1'b1, KEY_D};
      9'h029:  r = {1'b1, KEY_SPACE};
      9'h05A:  r = {1'b1, KEY_ENTER};
      9'h16B:  r = {1'b1, KEY_LEFT};
      9'h174:  r = {1'b1, KEY_RIGHT};
      default: r = '0;
    endcase
    return r;
  endfunction

  function automatic logic is_dropped(input logic [7:0] b);
    return (b == RSP_ACK) || (b == RSP_BAT) || (b == RSP_RESEND) ||
           (b == RSP_ECHO) || (b == PFX_PAUSE);
  endfunction

endpackage

// File: rtl/ps2_scancode_decoder.sv
// PS/2 set-2 prefix resolver: one key event per keystroke plus held-state for 8 game keys.
// Optional prefix-abandon timeout enabled by defining PS2_TIMEOUT_EN.
module ps2_scancode_decoder
  import ps2_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 130_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_done_tick,
  input  logic [7:0] dout,
  output logic       key_valid,
  output logic [7:0] key_code,
  output logic       key_ext,
  output logic       key_break,
  output logic       key_repeat,
  output logic [7:0] key_held
);

  if (TIMEOUT_CYCLES < 2) begin : g_cfg_check
    $error("TIMEOUT_CYCLES must be at least 2");
  end

  state_t     state, state_next;
  logic       emit, emit_ext, emit_brk;
  logic       hit;
  logic [2:0] idx;
  logic       expire;

`ifdef PS2_TIMEOUT_EN
  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES);
  logic [CW-1:0] tmo_cnt;

  assign expire = (state != IDLE) && (tmo_cnt == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst || rx_done_tick || state == IDLE || expire)
      tmo_cnt <= '0;
    else
      tmo_cnt <= tmo_cnt + 1'b1;
  end
`else
  assign expire = 1'b0;
`endif

  always_comb begin
    state_next = state;
    emit       = 1'b0;
    emit_ext   = 1'b0;
    emit_brk   = 1'b0;
    if (rx_done_tick) begin
      unique case (state)
        IDLE: begin
          if (dout == PFX_EXT)       state_next = EXT;
          else if (dout == PFX_BRK)  state_next = BRK;
          else if (!is_dropped(dout)) emit = 1'b1;
        end
        EXT: begin
          if (dout == PFX_BRK)       state_next = EXT_BRK;
          else if (dout != PFX_EXT) begin
            emit     = 1'b1;
            emit_ext = 1'b1;
          end
        end
        BRK: begin
          if (dout == PFX_EXT)       state_next = EXT_BRK;
          else if (dout != PFX_BRK) begin
            emit     = 1'b1;
            emit_brk = 1'b1;
          end
        end
        EXT_BRK: begin
          if (dout != PFX_EXT && dout != PFX_BRK) begin
            emit     = 1'b1;
            emit_ext = 1'b1;
            emit_brk = 1'b1;
          end
        end
        default: state_next = IDLE;
      endcase
      if (emit) state_next = IDLE;
    end else if (expire) begin
      state_next = IDLE;
    end
  end

  assign {hit, idx} = key_index(emit_ext, dout);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      key_valid  <= 1'b0;
      key_code   <= '0;
      key_ext    <= 1'b0;
      key_break  <= 1'b0;
      key_repeat <= 1'b0;
      key_held   <= '0;
    end else begin
      state      <= state_next;
      key_valid  <= emit;
      // Repeat is judged on the held bit before this event updates it.
      key_repeat <= emit && !emit_brk && hit && key_held[idx];
      if (emit) begin
        key_code  <= dout;
        key_ext   <= emit_ext;
        key_break <= emit_brk;
        if (hit) key_held[idx] <= !emit_brk;
      end
    end
  end

endmodule

// File: tb/tb_ps2_scancode_decoder.sv
// Self-checking bench for ps2_scancode_decoder: vector table feeding a scoreboard
// of expected key events, plus hand-written back-to-back, reset and timeout sequences.
module tb_ps2_scancode_decoder;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx_done_tick = 1'b0;
  logic [7:0] dout = '0;
  logic       key_valid;
  logic [7:0] key_code;
  logic       key_ext;
  logic       key_break;
  logic       key_repeat;
  logic [7:0] key_held;

  ps2_scancode_decoder #(.TIMEOUT_CYCLES(16)) dut (
    .clk          (clk),
    .rst          (rst),
    .rx_done_tick (rx_done_tick),
    .dout         (dout),
    .key_valid    (key_valid),
    .key_code     (key_code),
    .key_ext      (key_ext),
    .key_break    (key_break),
    .key_repeat   (key_repeat),
    .key_held     (key_held)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] b;
    bit         ev;
    logic [7:0] code;
    bit         ext;
    bit         brk;
    bit         rep;
    logic [7:0] held;
  } vec_t;

  typedef struct {
    logic [7:0] code;
    bit         ext;
    bit         brk;
    bit         rep;
    logic [7:0] held;
    int         due;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Event monitor: every key_valid cycle must match the oldest expectation.
  always @(negedge clk) begin
    if (!rst) begin
      if (key_valid) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_event: got code=%h ext=%0d brk=%0d at cycle %0d, required no event",
                   key_code, key_ext, key_break, cyc);
        end else begin
          exp_t e;
          e = sb.pop_front();
          if (key_code !== e.code || key_ext !== e.ext || key_break !== e.brk ||
              key_repeat !== e.rep || cyc != e.due) begin
            errors++;
            $display("FAIL event_fields: got code=%h ext=%0d brk=%0d rep=%0d cyc=%0d, required code=%h ext=%0d brk=%0d rep=%0d cyc=%0d",
                     key_code, key_ext, key_break, key_repeat, cyc, e.code, e.ext, e.brk, e.rep, e.due);
          end
          checks++;
          if (key_held !== e.held) begin
            errors++;
            $display("FAIL key_held: got %h, required %h (code=%h)", key_held, e.held, e.code);
          end
        end
      end else if (sb.size() != 0 && sb[0].due <= cyc) begin
        exp_t e;
        e = sb.pop_front();
        checks++;
        errors++;
        $display("FAIL missing_event: got no key_valid by cycle %0d, required code=%h", cyc, e.code);
      end
    end
  end

  task automatic push_exp(input logic [7:0] code, input bit ext, input bit brk, input bit rep,
                          input logic [7:0] held, input int due);
    exp_t e;
    e.code = code; e.ext = ext; e.brk = brk; e.rep = rep; e.held = held; e.due = due;
    sb.push_back(e);
  endtask

  task automatic send(input vec_t v);
    @(posedge clk); #1;
    rx_done_tick = 1'b1;
    dout = v.b;
    if (v.ev) push_exp(v.code, v.ext, v.brk, v.rep, v.held, cyc + 1);
    @(posedge clk); #1;
    rx_done_tick = 1'b0;
  endtask

  task automatic add(input logic [7:0] b, input bit ev, input logic [7:0] code, input bit ext,
                     input bit brk, input bit rep, input logic [7:0] held);
    vec_t v;
    v.b = b; v.ev = ev; v.code = code; v.ext = ext; v.brk = brk; v.rep = rep; v.held = held;
    vecs.push_back(v);
  endtask

  task automatic pulse_reset();
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
  endtask

  task automatic check_idle_outputs(input string name);
    checks++;
    if ({key_valid, key_code, key_ext, key_break, key_repeat, key_held} !== 20'h0) begin
      errors++;
      $display("FAIL %s: got valid=%0d code=%h ext=%0d brk=%0d rep=%0d held=%h, required all 0",
               name, key_valid, key_code, key_ext, key_break, key_repeat, key_held);
    end
  endtask

  task automatic check_held(input string name, input logic [7:0] want);
    checks++;
    if (key_held !== want) begin
      errors++;
      $display("FAIL %s: got key_held=%h, required %h", name, key_held, want);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    // {byte, event?, code, ext, brk, repeat, held-after}
    add(8'h1D, 1, 8'h1D, 0, 0, 0, 8'h01);  // W make
    add(8'h1D, 1, 8'h1D, 0, 0, 1, 8'h01);  // typematic
    add(8'hF0, 0, 8'h00, 0, 0, 0, 8'h00);
    add(8'h1D, 1, 8'h1D, 0, 1, 0, 8'h00);  // W break
    add(8'hE0, 0, 8'h00, 0, 0, 0, 8'h00);
    add(8'h6B, 1, 8'h6B, 1, 0, 0, 8'h40);  // LEFT make
    add(8'hE0, 0, 8'h00, 0, 0, 0, 8'h00);
    add(8'hF0, 0, 8'h00, 0, 0, 0, 8'h00);
    add(8'h6B, 1, 8'h6B, 1, 1, 0, 8'h00);  // LEFT break
    add(8'hE0, 0, 8'h00, 0, 0, 0, 8'h00);
    add(8'h5A, 1, 8'h5A, 1, 0, 0, 8'h00);  // keypad ENTER, untracked
    add(8'hFA, 0, 8'h00, 0, 0, 0, 8'h00);
    add(8'hAA, 0, 8'h00, 0, 0, 0, 8'h00);
    add(8'h5A, 1, 8'h5A, 0, 0, 0, 8'h20);  // ENTER make
    add(8'hF0, 0, 8'h00, 0, 0, 0, 8'h00);
    add(8'h6B, 1, 8'h6B, 0, 1, 0, 8'h20);  // non-ext 6B, untracked
    add(8'hF0, 0, 8'h00, 0, 0, 0, 8'h00);
    add(8'h5A, 1, 8'h5A, 0, 1, 0, 8'h00);  // ENTER break
    add(8'hF0, 0, 8'h00, 0, 0, 0, 8'h00);
    add(8'h29, 1, 8'h29, 0, 1, 0, 8'h00);  // break of unheld SPACE
    add(8'hE0, 0, 8'h00, 0, 0, 0, 8'h00);
    add(8'hF0, 0, 8'h00, 0, 0, 0, 8'h00);
    add(8'hE0, 0, 8'h00, 0, 0, 0, 8'h00);
    add(8'hF0, 0, 8'h00, 0, 0, 0, 8'h00);
    add(8'h74, 1, 8'h74, 1, 1, 0, 8'h00);  // RIGHT break via repeated prefixes
    add(8'hF0, 0, 8'h00, 0, 0, 0, 8'h00);
    add(8'hE0, 0, 8'h00, 0, 0, 0, 8'h00);
    add(8'h74, 1, 8'h74, 1, 1, 0, 8'h00);  // F0 E0 order also lands in EXT_BRK
    add(8'hEE, 0, 8'h00, 0, 0, 0, 8'h00);
    add(8'hFE, 0, 8'h00, 0, 0, 0, 8'h00);
    add(8'hE1, 0, 8'h00, 0, 0, 0, 8'h00);
    add(8'h29, 1, 8'h29, 0, 0, 0, 8'h10);  // SPACE make

    repeat (3) @(posedge clk);
    #1;
    check_idle_outputs("reset_state");
    rst = 1'b0;
    idle(2);
    check_idle_outputs("after_reset_release");

    foreach (vecs[i]) send(vecs[i]);
    idle(3);

    // Back-to-back strobes on consecutive cycles.
    pulse_reset();
    @(posedge clk); #1;
    rx_done_tick = 1'b1; dout = 8'h1C;
    push_exp(8'h1C, 0, 0, 0, 8'h02, cyc + 1);
    @(posedge clk); #1;
    dout = 8'h23;
    push_exp(8'h23, 0, 0, 0, 8'h0A, cyc + 1);
    @(posedge clk); #1;
    rx_done_tick = 1'b0;
    idle(3);
    check_held("b2b_held", 8'h0A);

    // Reset after E0 discards the prefix and clears held state.
    @(posedge clk); #1;
    rx_done_tick = 1'b1; dout = 8'hE0;
    @(posedge clk); #1;
    rx_done_tick = 1'b0;
    pulse_reset();
    check_idle_outputs("mid_prefix_reset");
    send('{b: 8'h74, ev: 1, code: 8'h74, ext: 0, brk: 0, rep: 0, held: 8'h00});
    idle(3);

    // Reset coinciding with a final byte suppresses its event.
    @(posedge clk); #1;
    rst = 1'b1; rx_done_tick = 1'b1; dout = 8'h1D;
    @(posedge clk); #1;
    rst = 1'b0; rx_done_tick = 1'b0;
    idle(3);
    check_held("reset_suppress_held", 8'h00);

    // Stalled break prefix: abandoned only when the timeout is built.
    pulse_reset();
    send('{b: 8'hF0, ev: 0, code: 8'h00, ext: 0, brk: 0, rep: 0, held: 8'h00});
    idle(20);
`ifdef PS2_TIMEOUT_EN
    send('{b: 8'h1D, ev: 1, code: 8'h1D, ext: 0, brk: 0, rep: 0, held: 8'h01});
`else
    send('{b: 8'h1D, ev: 1, code: 8'h1D, ext: 0, brk: 1, rep: 0, held: 8'h00});
`endif
    idle(4);

    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d outstanding events, required 0", sb.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion by 200000 time units, required finish");
    $fatal(1);
  end

endmodule
